// File: rtl/mem_dump_streamer.sv
// Purpose: after a HALT instruction, drain the pipeline then stream every (optionally nonzero) data-memory word with its address.
// Latency: DRAIN_CYCLES after HALT to first read; 2 cycles per skipped word, 3 cycles per emitted word plus stalls.
// Backpressure: EMIT holds dump_addr/dump_data/dump_valid until dump_ready; no memory read is issued while stalled.
module mem_dump_streamer #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int DRAIN_CYCLES = 10,
   parameter bit SKIP_ZERO    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              halted,
   output logic              busy,
   output logic              done
);

   // Drain counter counts down from DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
      (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      READ,
      CHECK,
      EMIT,
      DONE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                is_halt;

   assign is_halt  = (instr == 16'hE000) || (instr == 16'hE7FF);
   assign mem_addr = addr_cnt;

   // Scan controller: every output is registered alongside the state transition that implies it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         drain_cnt  <= '0;
         mem_rd_en  <= 1'b0;
         dump_valid <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         halted     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_halt) begin
                  halted    <= 1'b1;
                  busy      <= 1'b1;
                  drain_cnt <= DRAIN_LOAD;
                  if (DRAIN_CYCLES == 0) begin
                     state     <= READ;
                     mem_rd_en <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state     <= READ;
                  mem_rd_en <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            READ: begin
               // Read strobe is a single cycle; data returns while in CHECK.
               mem_rd_en <= 1'b0;
               state     <= CHECK;
            end
            CHECK: begin
               if ((mem_rdata != '0) || !SKIP_ZERO) begin
                  dump_data  <= mem_rdata;
                  dump_addr  <= addr_cnt;
                  dump_valid <= 1'b1;
                  state      <= EMIT;
               end else if (addr_cnt == ADDR_MAX) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  addr_cnt  <= addr_cnt + 1'b1;
                  mem_rd_en <= 1'b1;
                  state     <= READ;
               end
            end
            EMIT: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  if (addr_cnt == ADDR_MAX) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     addr_cnt  <= addr_cnt + 1'b1;
                     mem_rd_en <= 1'b1;
                     state     <= READ;
                  end
               end
            end
            DONE: begin
               // Terminal: the counter never wraps and the memory is never rescanned.
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Purpose: scoreboard bench for mem_dump_streamer with a skip-zero instance (A) and an emit-all instance (B).
// Latency: expected beats come from a list-building model of the memory image; beat timing is checked separately.
// Backpressure: dump_ready is held, stalled or randomised by the stimulus; the monitor checks beat stability.
module tb_mem_dump_streamer;

   logic        clk;
   logic        reset;
   logic [15:0] instr_a, instr_b;
   logic        rd_a, rd_b;
   logic [3:0]  addr_a, addr_b;
   logic [15:0] rdata_a, rdata_b;
   logic        valid_a, valid_b;
   logic        dump_ready, ready_b;
   logic [3:0]  daddr_a, daddr_b;
   logic [15:0] ddata_a, ddata_b;
   logic        halted_a, halted_b, busy_a, busy_b, done_a, done_b;

   logic [15:0] mem_a [16];
   logic [15:0] mem_b [16];
   logic [19:0] q_a [$];
   logic [19:0] q_b [$];

   int tests = 0;
   int fails = 0;
   int beats_a = 0, beats_b = 0, reads_a = 0;
   logic [3:0]  last_a;
   logic [15:0] last_d;

   mem_dump_streamer #(.ADDR_W(4), .DATA_W(16), .DRAIN_CYCLES(10), .SKIP_ZERO(1'b1)) dut_a (
      .clk(clk), .reset(reset), .instr(instr_a),
      .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
      .dump_valid(valid_a), .dump_ready(dump_ready), .dump_addr(daddr_a), .dump_data(ddata_a),
      .halted(halted_a), .busy(busy_a), .done(done_a)
   );

   mem_dump_streamer #(.ADDR_W(4), .DATA_W(16), .DRAIN_CYCLES(3), .SKIP_ZERO(1'b0)) dut_b (
      .clk(clk), .reset(reset), .instr(instr_b),
      .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
      .dump_valid(valid_b), .dump_ready(ready_b), .dump_addr(daddr_b), .dump_data(ddata_b),
      .halted(halted_b), .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read data memories
   always @(posedge clk) begin
      if (rd_a) rdata_a <= mem_a[addr_a];
      if (rd_b) rdata_b <= mem_b[addr_b];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the dump is the list of (address, word) pairs in address order, minus zeros when skipping.
   task automatic model_a();
      for (int a = 0; a < 16; a++)
         if (mem_a[a] != 16'h0) q_a.push_back({4'(a), mem_a[a]});
   endtask

   task automatic model_b();
      for (int a = 0; a < 16; a++)
         q_b.push_back({4'(a), mem_b[a]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
      q_a.delete();
      beats_a = 0;
   endtask

   task automatic rand_mem_a();
      for (int a = 0; a < 16; a++)
         mem_a[a] = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
   endtask

   task automatic run_to_done(input bit rnd, output int cyc);
      cyc = 0;
      while (!done_a && cyc < 2000) begin
         tick();
         cyc++;
         if (rnd) dump_ready = ($urandom_range(0, 3) != 0);
      end
      check("done_timeout", {31'b0, done_a}, 32'd1);
      dump_ready = 1'b1;
   endtask

   // Monitor A: pops the scoreboard on every accepted beat and checks stall stability and read exclusivity.
   logic        stall_a, prev_rd_a;
   logic [3:0]  hold_addr;
   logic [15:0] hold_data;
   initial begin
      stall_a = 1'b0;
      prev_rd_a = 1'b0;
   end
   always @(negedge clk) begin
      logic [19:0] e;
      if (reset) begin
         stall_a   = 1'b0;
         prev_rd_a = 1'b0;
      end else begin
         if (stall_a) begin
            check("hold_valid", {31'b0, valid_a}, 32'd1);
            check("hold_addr", {28'b0, daddr_a}, {28'b0, hold_addr});
            check("hold_data", {16'b0, ddata_a}, {16'b0, hold_data});
         end
         if (valid_a && dump_ready) begin
            if (q_a.size() == 0) begin
               check("unexpected_beat_a", {daddr_a, ddata_a}, 32'hFFFF_FFFF);
            end else begin
               e = q_a.pop_front();
               check("beat_addr_a", {28'b0, daddr_a}, {28'b0, e[19:16]});
               check("beat_data_a", {16'b0, ddata_a}, {16'b0, e[15:0]});
            end
            beats_a++;
            last_a = daddr_a;
            last_d = ddata_a;
         end
         if (rd_a) begin
            check("rd_excl_a", {31'b0, valid_a}, 32'd0);
            check("rd_gap_a", {31'b0, prev_rd_a}, 32'd0);
            reads_a++;
         end
         stall_a   = valid_a && !dump_ready;
         hold_addr = daddr_a;
         hold_data = ddata_a;
         prev_rd_a = rd_a;
      end
   end

   // Monitor B: emit-all instance, same scoreboard discipline.
   always @(negedge clk) begin
      logic [19:0] e;
      if (!reset && valid_b && ready_b) begin
         if (q_b.size() == 0) begin
            check("unexpected_beat_b", {daddr_b, ddata_b}, 32'hFFFF_FFFF);
         end else begin
            e = q_b.pop_front();
            check("beat_addr_b", {28'b0, daddr_b}, {28'b0, e[19:16]});
            check("beat_data_b", {16'b0, ddata_b}, {16'b0, e[15:0]});
         end
         beats_b++;
      end
      if (!reset && rd_b) check("rd_excl_b", {31'b0, valid_b}, 32'd0);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, rd_cyc, c, reads0;
      bit noisy;
      reset = 1'b1;
      instr_a = 16'h1234;
      instr_b = 16'h1234;
      dump_ready = 1'b1;
      ready_b = 1'b1;
      for (int a = 0; a < 16; a++) begin
         mem_a[a] = 16'h0;
         mem_b[a] = 16'h0;
      end

      // Test 1: reset state, then a non-HALT instruction keeps everything quiet
      do_reset(4);
      check("rst_halted", {31'b0, halted_a}, 32'd0);
      check("rst_busy", {31'b0, busy_a}, 32'd0);
      check("rst_done", {31'b0, done_a}, 32'd0);
      check("rst_valid", {31'b0, valid_a}, 32'd0);
      check("rst_rd", {31'b0, rd_a}, 32'd0);
      noisy = 1'b0;
      repeat (50) begin
         tick();
         if (halted_a || busy_a || done_a || valid_a || rd_a || halted_b || busy_b || done_b || valid_b || rd_b)
            noisy = 1'b1;
      end
      check("idle_quiet", {31'b0, noisy}, 32'd0);

      // Test 2: two nonzero words, ready always high, exact cycle timing
      do_reset(2);
      mem_a[2] = 16'h00AA;
      mem_a[9] = 16'hBEEF;
      model_a();
      instr_a = 16'hE000;
      tick();
      check("halted_next_edge", {31'b0, halted_a}, 32'd1);
      check("busy_drain", {31'b0, busy_a}, 32'd1);
      cyc = 1;
      while (!rd_a && cyc < 100) begin
         tick();
         cyc++;
      end
      check("first_rd_cycle", cyc, 32'd11);
      check("first_rd_addr", {28'b0, addr_a}, 32'd0);
      rd_cyc = cyc;
      while (!done_a && cyc < rd_cyc + 200) begin
         tick();
         cyc++;
      end
      check("done_cycle", cyc - rd_cyc, 32'd34);
      check("t2_beats", beats_a, 32'd2);
      check("t2_q_empty", q_a.size(), 32'd0);
      check("t2_busy_done", {31'b0, busy_a}, 32'd0);

      // Test 3: five-cycle stall on the first beat
      do_reset(2);
      model_a();
      dump_ready = 1'b0;
      instr_a = 16'hE000;
      cyc = 0;
      while (!valid_a && cyc < 200) begin
         tick();
         cyc++;
      end
      check("t3_valid_seen", {31'b0, valid_a}, 32'd1);
      repeat (5) begin
         check("t3_stall_valid", {31'b0, valid_a}, 32'd1);
         check("t3_stall_addr", {28'b0, daddr_a}, 32'd2);
         check("t3_stall_data", {16'b0, ddata_a}, 32'h00AA);
         check("t3_stall_no_rd", {31'b0, rd_a}, 32'd0);
         tick();
      end
      dump_ready = 1'b1;
      tick();
      check("t3_valid_drop", {31'b0, valid_a}, 32'd0);
      check("t3_one_accept", beats_a, 32'd1);
      run_to_done(1'b0, c);
      check("t3_beats", beats_a, 32'd2);
      check("t3_q_empty", q_a.size(), 32'd0);

      // Test 4: last address nonzero, random backpressure, terminal DONE
      do_reset(2);
      rand_mem_a();
      mem_a[15] = 16'hFFFF;
      model_a();
      instr_a = 16'hE7FF;
      run_to_done(1'b1, c);
      check("t4_last_addr", {28'b0, last_a}, 32'd15);
      check("t4_last_data", {16'b0, last_d}, 32'hFFFF);
      check("t4_q_empty", q_a.size(), 32'd0);
      reads0 = reads_a;
      noisy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         instr_a = (i % 2 == 0) ? 16'hE000 : 16'hE7FF;
         tick();
         if (valid_a || !done_a || busy_a || !halted_a) noisy = 1'b1;
      end
      check("t4_no_rescan", reads_a - reads0, 32'd0);
      check("t4_done_sticky", {31'b0, noisy}, 32'd0);

      // Test 5: reset in the middle of EMIT, then restart from address 0
      do_reset(2);
      rand_mem_a();
      mem_a[5] = 16'h1234;
      dump_ready = 1'b0;
      instr_a = 16'hE000;
      cyc = 0;
      while (!valid_a && cyc < 200) begin
         tick();
         cyc++;
      end
      check("t5_in_emit", {31'b0, valid_a}, 32'd1);
      reset = 1'b1;
      q_a.delete();
      tick();
      check("t5_rst_valid", {31'b0, valid_a}, 32'd0);
      check("t5_rst_busy", {31'b0, busy_a}, 32'd0);
      check("t5_rst_halted", {31'b0, halted_a}, 32'd0);
      reset = 1'b0;
      beats_a = 0;
      model_a();
      dump_ready = 1'b1;
      cyc = 0;
      while (!rd_a && cyc < 100) begin
         tick();
         cyc++;
      end
      check("t5_restart_addr", {28'b0, addr_a}, 32'd0);
      run_to_done(1'b1, c);
      check("t5_q_empty", q_a.size(), 32'd0);

      // Extra randomized scans against the model
      for (int r = 0; r < 3; r++) begin
         do_reset(2);
         rand_mem_a();
         model_a();
         instr_a = ($urandom_range(0, 1) == 0) ? 16'hE000 : 16'hE7FF;
         run_to_done(1'b1, c);
         check("rand_q_empty", q_a.size(), 32'd0);
      end
      instr_a = 16'h0;

      // Test 6: emit-all instance over an all-zero memory
      model_b();
      instr_b = 16'hE000;
      cyc = 0;
      while (!done_b && cyc < 500) begin
         tick();
         cyc++;
      end
      check("t6_done", {31'b0, done_b}, 32'd1);
      check("t6_beats", beats_b, 32'd16);
      check("t6_q_empty", q_b.size(), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_dump_streamer.md
Name: mem_dump_streamer

Overview:
- Hardware counterpart of the bench-side end-of-program dump.
- Sits beside the 16-bit CPU core in top and watches the decode-stage instruction.
- On a HALT encoding it waits for the pipeline to drain, then scans data memory through a synchronous read port.
- It streams every nonzero word, with its address, out over a valid/ready interface; "done" marks the end of the scan.

Parameters:
- ADDR_W, 16, data memory address width; the scan covers addresses 0 .. 2^ADDR_W-1.
- DATA_W, 16, data memory word width.
- DRAIN_CYCLES, 10, idle cycles between HALT detection and the first memory read (pipeline clear).
- SKIP_ZERO, 1, 1 = suppress words equal to 0; 0 = emit every word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  current core instruction.
- mem_rd_en  out  1  data memory read strobe.
- mem_addr  out  ADDR_W  data memory read address.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en.
- dump_valid  out  1  output beat valid.
- dump_ready  in  1  downstream accepts the beat.
- dump_addr  out  ADDR_W  address of the emitted word.
- dump_data  out  DATA_W  emitted word.
- halted  out  1  HALT seen; sticky until reset.
- busy  out  1  high in DRAIN, READ, CHECK and EMIT.
- done  out  1  scan complete; sticky until reset.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; address counter 0; drain counter 0. Reset takes effect at any state, including mid-EMIT (dump_valid drops on the next edge).
- HALT encodings: instr == 16'hE000 or instr == 16'hE7FF. Any other value is ignored.
- IDLE: on HALT, go to DRAIN (or READ if DRAIN_CYCLES == 0), set halted = 1, load the drain counter.
- DRAIN: stay exactly DRAIN_CYCLES cycles, then go to READ. instr is ignored from DRAIN onward, including repeated HALTs.
- READ (1 cycle): mem_rd_en = 1, mem_addr = address counter. Next state CHECK.
- CHECK (1 cycle): sample mem_rdata.
  - If mem_rdata != 0 or SKIP_ZERO == 0: register dump_data = mem_rdata and dump_addr = counter, go to EMIT.
  - Otherwise, if the counter is at its max value, go to DONE; else increment the counter and go to READ.
- EMIT: dump_valid = 1. dump_addr and dump_data are held stable while dump_ready == 0. mem_rd_en is 0.
  - When dump_valid && dump_ready: dump_valid drops next cycle.
  - If the counter is at max, go to DONE; else increment and go to READ.
- DONE: done = 1, busy = 0, dump_valid = 0. Terminal until reset. The counter never wraps and memory is never rescanned.
- mem_rd_en is asserted only in READ, and at most one read is outstanding.
- Throughput: a zero word costs 2 cycles; an emitted word costs at least 3 cycles plus any ready stall.
- The counter is ADDR_W bits. The max test is counter == {ADDR_W{1'b1}}; no increment happens past max.
- busy == 0 in IDLE and DONE. halted rises on the edge after HALT is sampled.

Test Plan:
1. Reset for 4 cycles, then instr = 16'h1234 for 50 cycles. All outputs stay 0 and mem_rd_en never asserts.
2. ADDR_W = 4, DRAIN_CYCLES = 10, mem[2] = 16'h00AA, mem[9] = 16'hBEEF, all other words 0, dump_ready = 1, instr = 16'hE000.
   - halted = 1 on the next edge.
   - First mem_rd_en (addr 0) 11 cycles after the edge that sampled the HALT.
   - Exactly two beats: (2, 16'h00AA) then (9, 16'hBEEF).
   - done = 1 at 34 cycles after the first mem_rd_en cycle.
3. Same setup as 2, but hold dump_ready = 0 for 5 cycles during the first beat. The beat stays at (2, 16'h00AA) with dump_valid = 1, there is no mem_rd_en during the stall, and the beat is accepted once when ready rises.
4. instr = 16'hE7FF, mem[15] = 16'hFFFF. The last beat is (15, 16'hFFFF), then done = 1. No read of address 0 follows, and a further HALT on instr changes nothing.
5. Assert reset mid-EMIT. dump_valid, busy and halted are 0 on the next edge. A new 16'hE000 restarts the scan from address 0.
6. SKIP_ZERO = 0, ADDR_W = 4, all memory 0, dump_ready = 1. Expect 16 beats with addresses 0..15 in order, all data 0, then done.
